mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 34 +++
 rtl/mem_arbiter.sv | 118 +++++++++++
 tb/tb_mem_arbiter.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bundle between the arbiter, its three requesters (fetch, data, debug) and the single-port memory.
// The slave modport is the arbiter side; the master modport is the requester and memory side.
interface mem_arbiter_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic [2:0]        req;
  logic [2:0]        we;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [ADDR_W-1:0] addr2;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic [DATA_W-1:0] wdata2;
  logic [2:0]        gnt;
  logic [2:0]        rvalid;
  logic [DATA_W-1:0] rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  modport slave (
    input  req, we, addr0, addr1, addr2, wdata0, wdata1, wdata2, mem_rdata,
    output gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output req, we, addr0, addr1, addr2, wdata0, wdata1, wdata2, mem_rdata,
    input  gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter for one outstanding access to a single-port memory.
// Define MEM_ARBITER_DEBUG_EN to let the debug port (index 2) join the rotation.
//
// state  | meaning
// IDLE   | waiting for a request, winner picked and launched on the next edge
// ACCESS | memory strobed, grant pulse to the winner
// RESP   | read data returned with rvalid to the winner
module mem_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
) (
  input  logic          clock,
  input  logic          reset_n,
  mem_arbiter_if.slave  bus
);

`ifdef MEM_ARBITER_DEBUG_EN
  localparam int         N        = 3;
  localparam logic [2:0] EN_MASK  = 3'b111;
  localparam logic [1:0] LAST_RST = 2'd2;
`else
  localparam int         N        = 2;
  localparam logic [2:0] EN_MASK  = 3'b011;
  localparam logic [1:0] LAST_RST = 2'd1;
`endif

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state_q;
  logic [1:0]        last_q;
  logic [1:0]        win_q;
  logic [2:0]        gnt_q;
  logic [2:0]        rvalid_q;
  logic              mem_en_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;

  logic [2:0]        req_en;
  logic [1:0]        win_d;
  logic [1:0]        cand;
  logic [ADDR_W-1:0] addr_sel;
  logic [DATA_W-1:0] wdata_sel;

  assign req_en = bus.req & EN_MASK;

  // Walk from lowest to highest priority so the nearest requester after last_q wins.
  always_comb begin
    win_d = last_q;
    cand  = '0;
    for (int k = N; k >= 1; k--) begin
      cand = 2'((int'(last_q) + k) % N);
      if (req_en[cand]) win_d = cand;
    end
  end

  always_comb begin
    case (win_d)
      2'd0:    begin addr_sel = bus.addr0; wdata_sel = bus.wdata0; end
      2'd1:    begin addr_sel = bus.addr1; wdata_sel = bus.wdata1; end
      default: begin addr_sel = bus.addr2; wdata_sel = bus.wdata2; end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      last_q      <= LAST_RST;
      win_q       <= '0;
      gnt_q       <= '0;
      rvalid_q    <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      gnt_q    <= '0;
      rvalid_q <= '0;
      mem_en_q <= 1'b0;
      mem_we_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|req_en) begin
            state_q     <= ACCESS;
            last_q      <= win_d;
            win_q       <= win_d;
            gnt_q       <= 3'(3'b001 << win_d);
            mem_en_q    <= 1'b1;
            mem_we_q    <= bus.we[win_d];
            mem_addr_q  <= addr_sel;
            mem_wdata_q <= wdata_sel;
          end
        end
        ACCESS: begin
          if (mem_we_q) begin
            state_q <= IDLE;
          end else begin
            state_q  <= RESP;
            rvalid_q <= 3'(3'b001 << win_q);
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.gnt       = gnt_q & EN_MASK;
  assign bus.rvalid    = rvalid_q & EN_MASK;
  // Memory data arrives in the RESP cycle, so it is forwarded rather than registered again.
  assign bus.rdata     = (|rvalid_q) ? bus.mem_rdata : '0;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: the bench plays requesters and a read-only memory with fixed contents.
// Contention expectations follow MEM_ARBITER_DEBUG_EN.
module tb_mem_arbiter;
  logic clock;
  logic reset_n;
  int   n_checks;
  int   n_errors;

  mem_arbiter_if #(.DATA_W(16), .ADDR_W(16)) bus ();

  mem_arbiter #(.DATA_W(16), .ADDR_W(16)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    case (a)
      16'h0004: mem_word = 16'h1234;
      16'h0020: mem_word = 16'hA000;
      16'h0021: mem_word = 16'hB000;
      16'h0022: mem_word = 16'hC000;
      default:  mem_word = a ^ 16'h5A5A;
    endcase
  endfunction

  always @(posedge clock)
    if (bus.mem_en && !bus.mem_we) bus.mem_rdata <= mem_word(bus.mem_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

`ifdef MEM_ARBITER_DEBUG_EN
  localparam int NCONT = 4;
  logic [2:0]  cont_gnt [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
  logic [15:0] cont_dat [4] = '{16'hA000, 16'hB000, 16'hC000, 16'hA000};
`else
  localparam int NCONT = 3;
  logic [2:0]  cont_gnt [3] = '{3'b001, 3'b010, 3'b001};
  logic [15:0] cont_dat [3] = '{16'hA000, 16'hB000, 16'hA000};
`endif

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset_n = 1'b0;
    bus.req = '0; bus.we = '0;
    bus.addr0 = '0; bus.addr1 = '0; bus.addr2 = '0;
    bus.wdata0 = '0; bus.wdata1 = '0; bus.wdata2 = '0;
    step(); step();
    check("rst_gnt", 32'(bus.gnt), 32'h0);
    check("rst_rvalid", 32'(bus.rvalid), 32'h0);
    check("rst_mem_en", 32'(bus.mem_en), 32'h0);
    check("rst_mem_we", 32'(bus.mem_we), 32'h0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'h0);
    check("rst_mem_wdata", 32'(bus.mem_wdata), 32'h0);
    check("rst_rdata", 32'(bus.rdata), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    reset_n = 1'b1;

    // single fetch read
    bus.req = 3'b001; bus.addr0 = 16'h0004;
    step();
    check("rd_gnt", 32'(bus.gnt), 32'h1);
    check("rd_mem_en", 32'(bus.mem_en), 32'h1);
    check("rd_mem_we", 32'(bus.mem_we), 32'h0);
    check("rd_mem_addr", 32'(bus.mem_addr), 32'h0004);
    check("rd_busy_a", 32'(bus.busy), 32'h1);
    check("rd_rvalid_a", 32'(bus.rvalid), 32'h0);
    bus.req = '0;
    step();
    check("rd_rvalid", 32'(bus.rvalid), 32'h1);
    check("rd_rdata", 32'(bus.rdata), 32'h1234);
    check("rd_gnt_r", 32'(bus.gnt), 32'h0);
    check("rd_mem_en_r", 32'(bus.mem_en), 32'h0);
    check("rd_busy_r", 32'(bus.busy), 32'h1);
    step();
    check("rd_busy_end", 32'(bus.busy), 32'h0);
    check("rd_rvalid_end", 32'(bus.rvalid), 32'h0);

    // data write
    bus.req = 3'b010; bus.we = 3'b010; bus.addr1 = 16'h0010; bus.wdata1 = 16'hBEEF;
    step();
    check("wr_gnt", 32'(bus.gnt), 32'h2);
    check("wr_mem_en", 32'(bus.mem_en), 32'h1);
    check("wr_mem_we", 32'(bus.mem_we), 32'h1);
    check("wr_mem_addr", 32'(bus.mem_addr), 32'h0010);
    check("wr_mem_wdata", 32'(bus.mem_wdata), 32'hBEEF);
    bus.req = '0; bus.we = '0;
    step();
    check("wr_rvalid", 32'(bus.rvalid), 32'h0);
    check("wr_busy", 32'(bus.busy), 32'h0);
    check("wr_mem_we_off", 32'(bus.mem_we), 32'h0);
    check("wr_hold_addr", 32'(bus.mem_addr), 32'h0010);

    // contention from a fresh reset, all requests held
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    bus.addr0 = 16'h0020; bus.addr1 = 16'h0021; bus.addr2 = 16'h0022;
    bus.req = 3'b111;
    for (int i = 0; i < NCONT; i++) begin
      step();
      check($sformatf("cont_gnt%0d", i), 32'(bus.gnt), 32'(cont_gnt[i]));
      check($sformatf("cont_rv_a%0d", i), 32'(bus.rvalid), 32'h0);
      step();
      check($sformatf("cont_rvalid%0d", i), 32'(bus.rvalid), 32'(cont_gnt[i]));
      check($sformatf("cont_rdata%0d", i), 32'(bus.rdata), 32'(cont_dat[i]));
      check($sformatf("cont_gnt_r%0d", i), 32'(bus.gnt), 32'h0);
      step();
    end

    // sole requester held back-to-back is granted every access
    bus.req = 3'b001;
    for (int i = 0; i < 2; i++) begin
      step();
      check($sformatf("b2b_gnt%0d", i), 32'(bus.gnt), 32'h1);
      step();
      check($sformatf("b2b_rdata%0d", i), 32'(bus.rdata), 32'hA000);
      step();
    end
    bus.req = '0;
    step();

    // reset during ACCESS of a fetch read
    bus.req = 3'b001;
    step();
    check("mid_gnt_pre", 32'(bus.gnt), 32'h1);
    reset_n = 1'b0;
    #1;
    check("mid_gnt", 32'(bus.gnt), 32'h0);
    check("mid_mem_en", 32'(bus.mem_en), 32'h0);
    check("mid_busy", 32'(bus.busy), 32'h0);
    check("mid_mem_addr", 32'(bus.mem_addr), 32'h0);
    bus.req = '0;
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("mid_no_rvalid%0d", i), 32'(bus.rvalid), 32'h0);
      check($sformatf("mid_no_gnt%0d", i), 32'(bus.gnt), 32'h0);
    end
    bus.req = 3'b011;
    step();
    check("mid_next_fetch", 32'(bus.gnt), 32'h1);
    bus.req = '0;
    step(); step();

    // request raised only during RESP is never served
    bus.req = 3'b010;
    step();
    check("drop_gnt_a", 32'(bus.gnt), 32'h2);
    bus.req = '0;
    step();
    check("drop_rvalid", 32'(bus.rvalid), 32'h2);
    check("drop_rdata", 32'(bus.rdata), 32'hB000);
    bus.req = 3'b001;
    step();
    bus.req = '0;
    check("drop_idle", 32'(bus.busy), 32'h0);
    step();
    check("drop_no_gnt", 32'(bus.gnt), 32'h0);
    check("drop_mem_en", 32'(bus.mem_en), 32'h0);
    check("drop_busy", 32'(bus.busy), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
